// File: rtl/iram_ctrl_pkg.sv
// Shared types and default command bytes for the instruction-RAM load sequencer.
package iram_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_READ  = 2'd0,
        MODE_WRITE = 2'd1,
        MODE_DBG   = 2'd2,
        MODE_PARK  = 2'd3
    } ram_mode_e;

    typedef enum logic [3:0] {
        IDLE,
        LD_LEN,
        LD_DATA,
        LD_ADV,
        DP_CLR,
        DP_SETTLE,
        DP_SEND,
        DP_STEP,
        FETCH,
        DBG
    } state_e;

    localparam int unsigned DELIM_DEF    = 32'h24;
    localparam int unsigned CMD_LOAD_DEF = 32'h4C;
    localparam int unsigned CMD_DUMP_DEF = 32'h44;

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchroniser bringing the raw debug button into the clk domain.
module btn_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/iram_load_sequencer.sv
// Arbitrates the instruction RAM between UART load/dump commands, CPU fetch and
// manual debug stepping; drives the RAM's MODE/data/address/DEBUG pins.
module iram_load_sequencer
    import iram_ctrl_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned MAX_ADDRESS = 255,
    parameter int unsigned DELIM       = DELIM_DEF,
    parameter int unsigned CMD_LOAD    = CMD_LOAD_DEF,
    parameter int unsigned CMD_DUMP    = CMD_DUMP_DEF,
    parameter int unsigned SETTLE      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] rx_data,
    input  logic         rx_valid,
    output logic [N-1:0] tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    input  logic [N-1:0] ram_data_out,
    output logic [1:0]   ram_mode,
    output logic [N-1:0] ram_data_in,
    output logic [N-1:0] ram_address,
    output logic         ram_debug,
    input  logic         cpu_req,
    input  logic [N-1:0] cpu_addr,
    output logic         cpu_grant,
    input  logic         dbg_en,
    input  logic         dbg_btn,
    output logic         busy,
    output logic         err,
    output logic [N-1:0] load_count
);

    localparam int unsigned NP1     = N + 1;
    localparam int unsigned LEN_CAP = (32'd1 << N) - 32'd1;
    localparam int unsigned MAX_LEN = ((MAX_ADDRESS + 1) > LEN_CAP) ? LEN_CAP : (MAX_ADDRESS + 1);
    localparam int unsigned SW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [N-1:0]   DELIM_B    = N'(DELIM);
    localparam logic [N-1:0]   CMD_LOAD_B = N'(CMD_LOAD);
    localparam logic [N-1:0]   CMD_DUMP_B = N'(CMD_DUMP);
    localparam logic [NP1-1:0] MAX_LEN_W  = NP1'(MAX_LEN);
    localparam logic [SW-1:0]  SETTLE_END = SW'(SETTLE - 1);

    state_e         state;
    ram_mode_e      mode_q;
    logic [NP1-1:0] rem;
    logic [NP1-1:0] cnt;
    logic [N-1:0]   len;
    logic [N-1:0]   pend;
    logic           first;
    logic           hold;
    logic [SW-1:0]  settle_cnt;
    logic           btn_s;
    logic           is_load;
    logic           is_dump;

    btn_sync2 u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   (dbg_btn),
        .q   (btn_s)
    );

    assign is_load  = rx_valid && (rx_data == CMD_LOAD_B);
    assign is_dump  = rx_valid && (rx_data == CMD_DUMP_B);
    assign ram_mode = mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= MODE_PARK;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            ram_data_in <= '0;
            ram_address <= '0;
            ram_debug   <= 1'b0;
            cpu_grant   <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            load_count  <= '0;
            rem         <= '0;
            cnt         <= '0;
            len         <= '0;
            pend        <= '0;
            first       <= 1'b0;
            hold        <= 1'b0;
            settle_cnt  <= '0;
        end else begin
            // Bytes that arrive while the sequencer cannot accept them are lost.
            if (rx_valid && (state inside {LD_ADV, DP_CLR, DP_SETTLE, DP_SEND, DP_STEP, FETCH})) begin
                err <= 1'b1;
            end

            case (state)
                IDLE, DBG: begin
                    ram_debug <= 1'b0;
                    if (is_load) begin
                        state  <= LD_LEN;
                        busy   <= 1'b1;
                        mode_q <= MODE_PARK;
                    end else if (is_dump) begin
                        if (load_count == '0) begin
                            err <= 1'b1;
                        end else begin
                            state  <= DP_CLR;
                            busy   <= 1'b1;
                            mode_q <= MODE_PARK;
                        end
                    end else if (cpu_req) begin
                        state       <= FETCH;
                        mode_q      <= MODE_PARK;
                        cpu_grant   <= 1'b1;
                        ram_address <= cpu_addr;
                    end else if (dbg_en) begin
                        state     <= DBG;
                        mode_q    <= MODE_DBG;
                        ram_debug <= btn_s;
                    end else begin
                        state  <= IDLE;
                        mode_q <= MODE_PARK;
                    end
                end

                LD_LEN: begin
                    if (rx_valid) begin
                        if (rx_data == '0 || NP1'(rx_data) > MAX_LEN_W) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            rem         <= NP1'(rx_data);
                            len         <= rx_data;
                            first       <= 1'b1;
                            hold        <= 1'b0;
                            ram_data_in <= '0;
                            mode_q      <= MODE_WRITE;
                            state       <= LD_DATA;
                        end
                    end
                end

                LD_DATA: begin
                    if (rem == '0) begin
                        // Keep the final byte on the pins for two cycles before parking.
                        if (hold) begin
                            load_count <= len;
                            mode_q     <= MODE_PARK;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            hold <= 1'b1;
                        end
                    end else if (rx_valid) begin
                        rem <= rem - NP1'(1);
                        if (rx_data == DELIM_B) begin
                            err <= 1'b1;
                        end else if (first) begin
                            ram_data_in <= rx_data;
                            first       <= 1'b0;
                        end else begin
                            ram_data_in <= DELIM_B;
                            pend        <= rx_data;
                            state       <= LD_ADV;
                        end
                    end
                end

                LD_ADV: begin
                    ram_data_in <= pend;
                    state       <= LD_DATA;
                end

                DP_CLR: begin
                    mode_q     <= MODE_DBG;
                    cnt        <= NP1'(load_count);
                    settle_cnt <= '0;
                    state      <= DP_SETTLE;
                end

                DP_SETTLE: begin
                    if (settle_cnt == SETTLE_END) begin
                        tx_data  <= ram_data_out;
                        tx_valid <= 1'b1;
                        state    <= DP_SEND;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end

                DP_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        cnt      <= cnt - NP1'(1);
                        if (cnt == NP1'(1)) begin
                            mode_q <= MODE_PARK;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            ram_debug <= 1'b1;
                            state     <= DP_STEP;
                        end
                    end
                end

                DP_STEP: begin
                    ram_debug  <= 1'b0;
                    settle_cnt <= '0;
                    state      <= DP_SETTLE;
                end

                FETCH: begin
                    mode_q      <= MODE_PARK;
                    ram_address <= cpu_addr;
                    if (cpu_req) begin
                        cpu_grant <= 1'b1;
                    end else begin
                        cpu_grant <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    mode_q <= MODE_PARK;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iram_load_sequencer.sv
// Directed bench for iram_load_sequencer with a pointer-based instruction RAM model.
module tb_iram_load_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] ram_data_out;
    logic [1:0] ram_mode;
    logic [7:0] ram_data_in;
    logic [7:0] ram_address;
    logic       ram_debug;
    logic       cpu_req;
    logic [7:0] cpu_addr;
    logic       cpu_grant;
    logic       dbg_en;
    logic       dbg_btn;
    logic       busy;
    logic       err;
    logic [7:0] load_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iram_load_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .ram_data_out (ram_data_out),
        .ram_mode     (ram_mode),
        .ram_data_in  (ram_data_in),
        .ram_address  (ram_address),
        .ram_debug    (ram_debug),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_grant    (cpu_grant),
        .dbg_en       (dbg_en),
        .dbg_btn      (dbg_btn),
        .busy         (busy),
        .err          (err),
        .load_count   (load_count)
    );

    // RAM model: write-advance on DELIM, debug step advances read pointer, park zeroes pointers.
    logic [7:0] mem [256];
    logic [7:0] wptr = 8'd0;
    logic [7:0] rptr = 8'd0;
    logic       dbg_prev = 1'b0;
    logic [1:0] prev_mode = 2'd0;
    logic [7:0] di_last = 8'd0;
    logic       di_have = 1'b0;
    int         dbg_pulses = 0;
    int         mode1_entries = 0;
    logic [7:0] di_q [$];
    logic [7:0] tx_q [$];

    assign ram_data_out = mem[rptr];

    always @(posedge clk) begin
        dbg_prev  <= ram_debug;
        prev_mode <= ram_mode;
        case (ram_mode)
            2'd1: if (ram_data_in == 8'h24) wptr <= wptr + 8'd1; else mem[wptr] <= ram_data_in;
            2'd2: if (ram_debug === 1'b1 && dbg_prev === 1'b0) rptr <= rptr + 8'd1;
            2'd3: begin wptr <= 8'd0; rptr <= 8'd0; end
            default: ;
        endcase
        if (ram_mode === 2'd1) begin
            if (!di_have || ram_data_in != di_last) di_q.push_back(ram_data_in);
            di_last <= ram_data_in;
            di_have <= 1'b1;
            if (prev_mode !== 2'd1) mode1_entries <= mode1_entries + 1;
        end else begin
            di_have <= 1'b0;
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_q.push_back(tx_data);
        if (ram_debug === 1'b1 && dbg_prev === 1'b0) dbg_pulses <= dbg_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen;
        int di0, tx0, dbg0, m1;
        logic [7:0] exp_di [6];
        exp_di = '{8'h00, 8'h11, 8'h24, 8'h22, 8'h24, 8'h33};

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        cpu_req = 1'b0; cpu_addr = 8'h00; dbg_en = 1'b0; dbg_btn = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_mode", ram_mode, 2'd3);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_load_count", load_count, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_grant", cpu_grant, 1'b0);
        check("rst_data_in", ram_data_in, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Load three bytes
        di0 = di_q.size();
        m1  = mode1_entries;
        send_rx(8'h4C);
        check("ld_busy_len", busy, 1'b1);
        send_rx(8'h03);
        send_rx(8'h11);
        send_rx(8'h22);
        send_rx(8'h33);
        wait_idle(20, ok);
        check("ld_done", ok, 1'b1);
        check("ld_load_count", load_count, 8'h03);
        check("ld_mode_park", ram_mode, 2'd3);
        check("ld_err", err, 1'b0);
        check("ld_di_len", di_q.size() - di0, 6);
        for (int k = 0; k < 6; k++) begin
            if (di0 + k < di_q.size()) check($sformatf("ld_di_%0d", k), di_q[di0 + k], exp_di[k]);
        end
        check("ld_mode1_once", mode1_entries - m1, 1);
        check("ld_mem0", mem[0], 8'h11);
        check("ld_mem1", mem[1], 8'h22);
        check("ld_mem2", mem[2], 8'h33);

        // Dump back with TX always ready
        tx_ready = 1'b1;
        tx0  = tx_q.size();
        dbg0 = dbg_pulses;
        send_rx(8'h44);
        wait_idle(300, ok);
        check("dp_done", ok, 1'b1);
        check("dp_tx_count_at_busy_fall", tx_q.size() - tx0, 3);
        if (tx_q.size() >= tx0 + 3) begin
            check("dp_tx0", tx_q[tx0], 8'h11);
            check("dp_tx1", tx_q[tx0 + 1], 8'h22);
            check("dp_tx2", tx_q[tx0 + 2], 8'h33);
        end
        check("dp_dbg_pulses", dbg_pulses - dbg0, 2);
        check("dp_err", err, 1'b0);
        check("dp_mode_park", ram_mode, 2'd3);

        // Reset mid-payload aborts the load
        send_rx(8'h4C);
        send_rx(8'h03);
        send_rx(8'h77);
        send_rx(8'h88);
        check("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_mode", ram_mode, 2'd3);
        check("abort_busy", busy, 1'b0);
        check("abort_load_count", load_count, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Zero length is rejected without ever writing
        m1 = mode1_entries;
        send_rx(8'h4C);
        send_rx(8'h00);
        check("len0_err", err, 1'b1);
        check("len0_busy", busy, 1'b0);
        check("len0_no_write", mode1_entries - m1, 0);

        // A DELIM payload byte is dropped but still counts against the length
        pulse_rst();
        check("delim_err_clear", err, 1'b0);
        send_rx(8'h4C);
        send_rx(8'h02);
        send_rx(8'h24);
        check("delim_err", err, 1'b1);
        send_rx(8'h55);
        wait_idle(20, ok);
        check("delim_done", ok, 1'b1);
        check("delim_load_count", load_count, 8'h02);
        check("delim_mem0", mem[0], 8'h55);

        // CPU fetch ownership
        pulse_rst();
        cpu_addr = 8'h05;
        cpu_req  = 1'b1;
        @(negedge clk);
        check("fetch_grant", cpu_grant, 1'b1);
        check("fetch_addr", ram_address, 8'h05);
        check("fetch_mode", ram_mode, 2'd3);
        cpu_addr = 8'h9A;
        @(negedge clk);
        check("fetch_addr_follow", ram_address, 8'h9A);
        check("fetch_err_before", err, 1'b0);
        send_rx(8'h4C);
        check("fetch_rx_err", err, 1'b1);
        check("fetch_rx_dropped", busy, 1'b0);
        check("fetch_grant_hold", cpu_grant, 1'b1);
        cpu_req = 1'b0;
        @(negedge clk);
        check("fetch_release", cpu_grant, 1'b0);
        @(negedge clk);
        check("fetch_idle_busy", busy, 1'b0);

        // Debug stepping, then a dump preempts it
        send_rx(8'h4C);
        send_rx(8'h03);
        send_rx(8'hA1);
        send_rx(8'hB2);
        send_rx(8'hC3);
        wait_idle(20, ok);
        check("dbg_load_count", load_count, 8'h03);
        dbg_en = 1'b1;
        @(negedge clk);
        check("dbg_mode", ram_mode, 2'd2);
        dbg_btn = 1'b1;
        @(negedge clk);
        check("dbg_btn_not_yet", ram_debug, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ram_debug === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("dbg_btn_follow", seen, 1'b1);
        dbg_btn = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ram_debug === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check("dbg_btn_release", seen, 1'b1);
        check("dbg_mode_hold", ram_mode, 2'd2);

        tx_ready = 1'b0;
        tx0 = tx_q.size();
        rx_data  = 8'h44;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("preempt_busy", busy, 1'b1);
        check("preempt_mode_park", ram_mode, 2'd3);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("preempt_tx_valid", seen, 1'b1);
        repeat (3) @(negedge clk);
        check("preempt_tx_hold", tx_valid, 1'b1);
        check("preempt_tx_data", tx_data, 8'hA1);
        tx_ready = 1'b1;
        wait_idle(300, ok);
        check("preempt_done", ok, 1'b1);
        check("preempt_tx_count", tx_q.size() - tx0, 3);
        if (tx_q.size() >= tx0 + 3) begin
            check("preempt_tx0", tx_q[tx0], 8'hA1);
            check("preempt_tx1", tx_q[tx0 + 1], 8'hB2);
            check("preempt_tx2", tx_q[tx0 + 2], 8'hC3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
